// File: rtl/floppy_seek_ctrl.sv
// floppy_seek_ctrl
// Head-positioning and spindle controller for a floppy drive. It accepts
// recalibrate/seek commands over a valid/ready handshake and drives MOTOR,
// STEP and DIR with the drive's step pulse width, step rate and head-settle
// timing. It tracks the current cylinder, reports completion and errors, and
// counts index pulses for motor spin-up and the idle motor-off timeout.
//
// Ports:
//   i_Clk, i_Reset     clock, synchronous active-high reset
//   i_Cmd_Valid        command request
//   o_Cmd_Ready        high in IDLE; a command is taken on Valid && Ready
//   i_Cmd_Recal        1 = recalibrate to track 0, 0 = seek to i_Cmd_Track
//   i_Cmd_Track[6:0]   seek target cylinder
//   i_Track0, i_Index  asynchronous drive status inputs (active-high)
//   o_Motor            spindle motor enable
//   o_Step             step pulse, active-high
//   o_Dir              1 = inward (track+1), 0 = outward (track-1)
//   o_Track[6:0]       current cylinder
//   o_Track_Valid      o_Track is trustworthy (a recalibrate has completed)
//   o_Busy             command in progress
//   o_Done             one-cycle completion pulse
//   o_Error            last command failed; held until the next accept
module floppy_seek_ctrl #(
    parameter int clkspd       = 25000000,
    parameter int STEP_PULSE   = clkspd / 1000000 * 2,
    parameter int STEP_PERIOD  = clkspd / 1000 * 3,
    parameter int SETTLE       = clkspd / 1000 * 15,
    parameter int SPINUP_IDX   = 2,
    parameter int IDLE_IDX_OFF = 10,
    parameter int MAX_TRACK    = 79,
    parameter int RECAL_MAX    = 84
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Cmd_Valid,
    output logic       o_Cmd_Ready,
    input  logic       i_Cmd_Recal,
    input  logic [6:0] i_Cmd_Track,
    input  logic       i_Track0,
    input  logic       i_Index,
    output logic       o_Motor,
    output logic       o_Step,
    output logic       o_Dir,
    output logic [6:0] o_Track,
    output logic       o_Track_Valid,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Error
);

    localparam int TIMER_MAX = (STEP_PERIOD > SETTLE) ? STEP_PERIOD : SETTLE;
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam int IDX_MAX   = (SPINUP_IDX > IDLE_IDX_OFF) ? SPINUP_IDX : IDLE_IDX_OFF;
    localparam int IW        = $clog2(IDX_MAX + 1);
    localparam int SW        = $clog2(RECAL_MAX + 1);

    localparam logic [TW-1:0] HI_LAST      = TW'(STEP_PULSE - 1);
    localparam logic [TW-1:0] LO_LAST      = TW'(STEP_PERIOD - STEP_PULSE - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE - 1);
    localparam logic [IW-1:0] SPINUP_CNT   = IW'(SPINUP_IDX);
    localparam logic [IW-1:0] IDLE_OFF_CNT = IW'(IDLE_IDX_OFF);
    localparam logic [SW-1:0] RECAL_LIMIT  = SW'(RECAL_MAX);
    localparam logic [6:0]    TRACK_LIMIT  = 7'(MAX_TRACK);

    typedef enum logic [2:0] {
        S_IDLE, S_SPINUP, S_CHECK, S_STEP_HI, S_STEP_LO, S_SETTLE, S_DONE
    } state_t;

    state_t        state, state_next;
    logic          cmd_recal, cmd_recal_next;
    logic [6:0]    cmd_track, cmd_track_next;
    logic [6:0]    track, track_next;
    logic          track_valid, track_valid_next;
    logic          motor, motor_next;
    logic          dir, dir_next;
    logic          step, step_next;
    logic          done, done_next;
    logic          error, error_next;
    logic [SW-1:0] step_cnt, step_cnt_next;
    logic [TW-1:0] timer, timer_next;
    logic [IW-1:0] idx_cnt, idx_cnt_next;

    logic track0_meta, track0_sync;
    logic index_meta, index_sync, index_prev;
    logic index_rise;

    logic [IW-1:0] idx_inc;
    logic [SW-1:0] step_inc;
    logic [TW-1:0] timer_inc;

    assign index_rise = index_sync & ~index_prev;
    assign idx_inc    = idx_cnt + 1'b1;
    assign step_inc   = step_cnt + 1'b1;
    assign timer_inc  = timer + 1'b1;

    // Two-flop synchronizers for the asynchronous drive status lines, plus
    // one more flop on INDEX for rising-edge detection.
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_Reset) begin
            track0_meta <= 1'b0;
            track0_sync <= 1'b0;
            index_meta  <= 1'b0;
            index_sync  <= 1'b0;
            index_prev  <= 1'b0;
        end else begin
            track0_meta <= i_Track0;
            track0_sync <= track0_meta;
            index_meta  <= i_Index;
            index_sync  <= index_meta;
            index_prev  <= index_sync;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            cmd_recal   <= 1'b0;
            cmd_track   <= '0;
            track       <= '0;
            track_valid <= 1'b0;
            motor       <= 1'b0;
            dir         <= 1'b0;
            step        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            step_cnt    <= '0;
            timer       <= '0;
            idx_cnt     <= '0;
        end else begin
            state       <= state_next;
            cmd_recal   <= cmd_recal_next;
            cmd_track   <= cmd_track_next;
            track       <= track_next;
            track_valid <= track_valid_next;
            motor       <= motor_next;
            dir         <= dir_next;
            step        <= step_next;
            done        <= done_next;
            error       <= error_next;
            step_cnt    <= step_cnt_next;
            timer       <= timer_next;
            idx_cnt     <= idx_cnt_next;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_next       = state;
        cmd_recal_next   = cmd_recal;
        cmd_track_next   = cmd_track;
        track_next       = track;
        track_valid_next = track_valid;
        motor_next       = motor;
        dir_next         = dir;
        error_next       = error;
        step_cnt_next    = step_cnt;
        timer_next       = timer;
        idx_cnt_next     = idx_cnt;

        case (state)
            S_IDLE: begin
                if (i_Cmd_Valid) begin
                    cmd_recal_next = i_Cmd_Recal;
                    cmd_track_next = i_Cmd_Track;
                    error_next     = 1'b0;
                    idx_cnt_next   = '0;
                    dir_next       = !i_Cmd_Recal && (i_Cmd_Track > track);
                    if (!i_Cmd_Recal && (!track_valid || i_Cmd_Track > TRACK_LIMIT)) begin
                        // Unknown position or illegal target: fail without
                        // touching the motor.
                        error_next = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        motor_next    = 1'b1;
                        step_cnt_next = '0;
                        timer_next    = '0;
                        state_next    = motor ? S_CHECK : S_SPINUP;
                    end
                end else if (motor && index_rise && idx_cnt != IDLE_OFF_CNT) begin
                    // Motor-off timeout; the count saturates at the threshold.
                    idx_cnt_next = idx_inc;
                    if (idx_inc == IDLE_OFF_CNT) begin
                        motor_next = 1'b0;
                    end
                end
            end

            S_SPINUP: begin
                if (index_rise) begin
                    idx_cnt_next = idx_inc;
                    if (idx_inc == SPINUP_CNT) begin
                        state_next = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                timer_next = '0;
                if (cmd_recal) begin
                    if (track0_sync) begin
                        track_next       = '0;
                        track_valid_next = 1'b1;
                        state_next       = (step_cnt != '0) ? S_SETTLE : S_DONE;
                    end else if (step_cnt == RECAL_LIMIT) begin
                        error_next       = 1'b1;
                        track_valid_next = 1'b0;
                        state_next       = S_DONE;
                    end else begin
                        step_cnt_next = step_inc;
                        state_next    = S_STEP_HI;
                    end
                end else if (track == cmd_track) begin
                    state_next = (step_cnt != '0) ? S_SETTLE : S_DONE;
                end else begin
                    // Direction was fixed at accept, so this never wraps.
                    step_cnt_next = step_inc;
                    track_next    = dir ? track + 1'b1 : track - 1'b1;
                    state_next    = S_STEP_HI;
                end
            end

            S_STEP_HI: begin
                if (timer == HI_LAST) begin
                    timer_next = '0;
                    state_next = S_STEP_LO;
                end else begin
                    timer_next = timer_inc;
                end
            end

            S_STEP_LO: begin
                if (timer == LO_LAST) begin
                    state_next = S_CHECK;
                end else begin
                    timer_next = timer_inc;
                end
            end

            S_SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    state_next = S_DONE;
                end else begin
                    timer_next = timer_inc;
                end
            end

            S_DONE: begin
                idx_cnt_next = '0;
                state_next   = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase

        // STEP and DONE are registered from the next state so the drive pin
        // is glitch-free and rises on the same edge that enters STEP_HI.
        step_next = (state_next == S_STEP_HI);
        done_next = (state_next == S_DONE);
    end

    assign o_Cmd_Ready   = (state == S_IDLE);
    assign o_Busy        = !o_Cmd_Ready;
    assign o_Motor       = motor;
    assign o_Step        = step;
    assign o_Dir         = dir;
    assign o_Track       = track;
    assign o_Track_Valid = track_valid;
    assign o_Done        = done;
    assign o_Error       = error;

endmodule

// File: tb/tb_floppy_seek_ctrl.sv
// Directed bench for floppy_seek_ctrl with shortened timing. A simple drive
// model moves a head position on each STEP rising edge and asserts TRACK0 at
// position 0; an index generator pulses INDEX every 200 cycles.
module tb_floppy_seek_ctrl;

    logic       clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Cmd_Valid = 1'b0;
    logic       i_Cmd_Recal = 1'b0;
    logic [6:0] i_Cmd_Track = '0;
    logic       i_Track0;
    logic       i_Index = 1'b0;
    logic       o_Cmd_Ready, o_Motor, o_Step, o_Dir, o_Track_Valid;
    logic       o_Busy, o_Done, o_Error;
    logic [6:0] o_Track;

    int compared = 0;
    int mismatched = 0;

    floppy_seek_ctrl #(
        .STEP_PULSE(4), .STEP_PERIOD(20), .SETTLE(50),
        .SPINUP_IDX(2), .IDLE_IDX_OFF(3), .MAX_TRACK(79), .RECAL_MAX(84)
    ) dut (
        .i_Clk(clk), .i_Reset(i_Reset),
        .i_Cmd_Valid(i_Cmd_Valid), .o_Cmd_Ready(o_Cmd_Ready),
        .i_Cmd_Recal(i_Cmd_Recal), .i_Cmd_Track(i_Cmd_Track),
        .i_Track0(i_Track0), .i_Index(i_Index),
        .o_Motor(o_Motor), .o_Step(o_Step), .o_Dir(o_Dir),
        .o_Track(o_Track), .o_Track_Valid(o_Track_Valid),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Index generator: 10-cycle pulses every 200 cycles, new pulses gated by idx_en.
    logic idx_en = 1'b1;
    int   idx_timer = 0;
    int   idx_hold = 0;
    always @(negedge clk) begin
        idx_timer = (idx_timer == 199) ? 0 : idx_timer + 1;
        if (idx_timer == 100 && idx_en) idx_hold = 10;
        else if (idx_hold > 0) idx_hold--;
        i_Index = (idx_hold > 0);
    end

    // Drive head model.
    int   pos = 0;
    logic t0_off = 1'b0;
    assign i_Track0 = !t0_off && (pos == 0);

    // Output monitor, sampled 1 time unit after each rising edge.
    int         n_rise = 0, n_done = 0, n_idx = 0;
    int         width_bad = 0, spacing_bad = 0, dir_bad = 0;
    int         first_rise_cyc = 0, first_rise_idx = 0, last_rise = 0, done_cyc = 0;
    int         hi_len = 0;
    logic       exp_dir = 1'b0;
    logic       step_prev = 1'b0, idx_prev = 1'b0;
    logic [6:0] trk_at_rise [8];

    always @(posedge clk) begin
        #1;
        if (o_Step && !step_prev) begin
            if (n_rise > 0 && (cyc - last_rise) != 21) spacing_bad++;
            if (n_rise == 0) begin
                first_rise_cyc = cyc;
                first_rise_idx = n_idx;
            end
            if (o_Dir !== exp_dir) dir_bad++;
            if (n_rise < 8) trk_at_rise[n_rise] = o_Track;
            last_rise = cyc;
            n_rise++;
            hi_len = 1;
            pos = o_Dir ? pos + 1 : pos - 1;
        end else if (o_Step) begin
            hi_len++;
        end
        if (!o_Step && step_prev && hi_len != 4) width_bad++;
        if (o_Done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (i_Index && !idx_prev) n_idx++;
        step_prev = o_Step;
        idx_prev  = i_Index;
    end

    int accept_cyc = 0;

    task automatic clear_mon();
        n_rise = 0; width_bad = 0; spacing_bad = 0; dir_bad = 0; n_idx = 0;
    endtask

    task automatic send_cmd(input logic recal, input logic [6:0] trk);
        int k = 0;
        i_Cmd_Valid = 1'b1;
        i_Cmd_Recal = recal;
        i_Cmd_Track = trk;
        while (!o_Cmd_Ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (!o_Cmd_Ready) begin
            mismatched++;
            $display("FAIL accept_timeout: ready=%b after %0d cycles, want 1", o_Cmd_Ready, k);
        end
        @(negedge clk);
        accept_cyc = cyc;
        i_Cmd_Valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base);
        int k = 0;
        while (n_done == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (n_done == base) begin
            mismatched++;
            $display("FAIL done_timeout: no o_Done within %0d cycles, want one", budget);
        end
    endtask

    task automatic test_reset();
        logic [14:0] got;
        i_Reset = 1'b1;
        repeat (3) @(negedge clk);
        i_Reset = 1'b0;
        got = {o_Cmd_Ready, o_Busy, o_Motor, o_Step, o_Dir, o_Track_Valid, o_Done, o_Error, o_Track};
        compared++;
        if (got !== {8'b1000_0000, 7'd0}) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b want %b", got, {8'b1000_0000, 7'd0});
        end
    endtask

    task automatic test_seek_unrecal();
        int base = n_done;
        clear_mon();
        send_cmd(1'b0, 7'd10);
        wait_done(50, base);
        compared++;
        if ({o_Error, o_Track_Valid, o_Motor, o_Track} !== {3'b100, 7'd0}) begin
            mismatched++;
            $display("FAIL unrecal_seek: err/valid/motor/track=%b/%b/%b/%0d want 1/0/0/0",
                     o_Error, o_Track_Valid, o_Motor, o_Track);
        end
        compared++;
        if (n_rise !== 0) begin
            mismatched++;
            $display("FAIL unrecal_steps: got %0d want 0", n_rise);
        end
    endtask

    task automatic test_recal();
        int base = n_done;
        pos = 5; t0_off = 1'b0; exp_dir = 1'b0;
        clear_mon();
        send_cmd(1'b1, 7'd0);
        compared++;
        if (o_Motor !== 1'b1) begin
            mismatched++;
            $display("FAIL recal_motor_on: got %b want 1", o_Motor);
        end
        wait_done(3000, base);
        compared++;
        if (n_rise !== 5) begin
            mismatched++;
            $display("FAIL recal_steps: got %0d want 5", n_rise);
        end
        compared++;
        if ({width_bad, spacing_bad, dir_bad} !== {32'd0, 32'd0, 32'd0}) begin
            mismatched++;
            $display("FAIL recal_pulse_shape: width_bad=%0d spacing_bad=%0d dir_bad=%0d want 0/0/0",
                     width_bad, spacing_bad, dir_bad);
        end
        compared++;
        if (first_rise_idx < 2) begin
            mismatched++;
            $display("FAIL recal_spinup: got %0d index edges before first step want >=2", first_rise_idx);
        end
        compared++;
        if (done_cyc - last_rise !== 71) begin
            mismatched++;
            $display("FAIL recal_settle: got %0d cycles last step to done want 71", done_cyc - last_rise);
        end
        compared++;
        if ({o_Error, o_Track_Valid, o_Track} !== {2'b01, 7'd0}) begin
            mismatched++;
            $display("FAIL recal_result: err/valid/track=%b/%b/%0d want 0/1/0",
                     o_Error, o_Track_Valid, o_Track);
        end
    endtask

    task automatic test_seek(input logic [6:0] target, input logic dir_want,
                             input int steps_want, input logic [20:0] trk_want);
        int base = n_done;
        exp_dir = dir_want;
        clear_mon();
        send_cmd(1'b0, target);
        wait_done(500, base);
        compared++;
        if (n_rise !== steps_want || dir_bad !== 0) begin
            mismatched++;
            $display("FAIL seek%0d_steps: got %0d steps, %0d bad dir want %0d, 0",
                     target, n_rise, dir_bad, steps_want);
        end
        compared++;
        if (first_rise_cyc - accept_cyc !== 1) begin
            mismatched++;
            $display("FAIL seek%0d_no_spinup: first step %0d cycles after accept want 1",
                     target, first_rise_cyc - accept_cyc);
        end
        compared++;
        if ({trk_at_rise[0], trk_at_rise[1], trk_at_rise[2]} !== trk_want) begin
            mismatched++;
            $display("FAIL seek%0d_track_seq: got %0d,%0d,%0d want %0d,%0d,%0d", target,
                     trk_at_rise[0], trk_at_rise[1], trk_at_rise[2],
                     trk_want[20:14], trk_want[13:7], trk_want[6:0]);
        end
        compared++;
        if ({o_Error, o_Track} !== {1'b0, target}) begin
            mismatched++;
            $display("FAIL seek%0d_result: err/track=%b/%0d want 0/%0d", target, o_Error, o_Track, target);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (n_done - base !== 1) begin
            mismatched++;
            $display("FAIL seek%0d_done_count: got %0d want 1", target, n_done - base);
        end
    endtask

    task automatic test_boundary();
        int base = n_done;
        clear_mon();
        send_cmd(1'b0, 7'd1);
        wait_done(50, base);
        compared++;
        if (done_cyc - accept_cyc !== 1 || n_rise !== 0) begin
            mismatched++;
            $display("FAIL seek_same_track: done %0d cycles after accept, %0d steps want 1, 0",
                     done_cyc - accept_cyc, n_rise);
        end
        base = n_done;
        send_cmd(1'b0, 7'd80);
        wait_done(50, base);
        compared++;
        if ({o_Error, o_Track_Valid, o_Track} !== {2'b11, 7'd1}) begin
            mismatched++;
            $display("FAIL seek_80: err/valid/track=%b/%b/%0d want 1/1/1", o_Error, o_Track_Valid, o_Track);
        end
        compared++;
        if (done_cyc - accept_cyc !== 0) begin
            mismatched++;
            $display("FAIL seek_80_latency: done %0d cycles after accept want 0", done_cyc - accept_cyc);
        end
    endtask

    task automatic test_recal_fail();
        int base = n_done;
        int k = 0;
        t0_off = 1'b1; exp_dir = 1'b0;
        clear_mon();
        send_cmd(1'b1, 7'd0);
        while (n_rise == 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        idx_en = 1'b0;
        repeat (30) @(negedge clk);
        i_Cmd_Valid = 1'b1; i_Cmd_Recal = 1'b0; i_Cmd_Track = 7'd5;
        compared++;
        if ({o_Cmd_Ready, o_Busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL busy_ready: ready/busy=%b/%b want 0/1", o_Cmd_Ready, o_Busy);
        end
        @(negedge clk);
        i_Cmd_Valid = 1'b0;
        wait_done(4000, base);
        compared++;
        if (n_rise !== 84) begin
            mismatched++;
            $display("FAIL recal_fail_steps: got %0d want 84", n_rise);
        end
        compared++;
        if ({o_Error, o_Track_Valid, width_bad, spacing_bad} !== {2'b10, 32'd0, 32'd0}) begin
            mismatched++;
            $display("FAIL recal_fail_result: err/valid=%b/%b width_bad=%0d spacing_bad=%0d want 1/0/0/0",
                     o_Error, o_Track_Valid, width_bad, spacing_bad);
        end
        repeat (20) @(negedge clk);
        compared++;
        if (n_done - base !== 1) begin
            mismatched++;
            $display("FAIL busy_cmd_ignored: got %0d done pulses want 1", n_done - base);
        end
        t0_off = 1'b0;
    endtask

    task automatic test_motor_off();
        int k = 0;
        clear_mon();
        idx_en = 1'b1;
        while (n_idx < 2 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        compared++;
        if (o_Motor !== 1'b1 || n_idx !== 2) begin
            mismatched++;
            $display("FAIL motor_after_2_idx: motor=%b edges=%0d want 1, 2", o_Motor, n_idx);
        end
        k = 0;
        while (n_idx < 3 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        compared++;
        if (o_Motor !== 1'b0 || n_idx !== 3) begin
            mismatched++;
            $display("FAIL motor_after_3_idx: motor=%b edges=%0d want 0, 3", o_Motor, n_idx);
        end
    endtask

    task automatic test_reset_mid_step();
        logic [11:0] got;
        int base = n_done;
        int k = 0;
        pos = 2; exp_dir = 1'b0;
        clear_mon();
        send_cmd(1'b1, 7'd0);
        wait_done(2000, base);
        compared++;
        if ({n_rise, o_Track_Valid} !== {32'd2, 1'b1}) begin
            mismatched++;
            $display("FAIL recal2: steps/valid=%0d/%b want 2/1", n_rise, o_Track_Valid);
        end
        send_cmd(1'b0, 7'd5);
        while (!o_Step && k < 200) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if ({o_Step, o_Track} !== {1'b1, 7'd1}) begin
            mismatched++;
            $display("FAIL mid_step: step/track=%b/%0d want 1/1", o_Step, o_Track);
        end
        i_Reset = 1'b1;
        @(negedge clk);
        got = {o_Step, o_Motor, o_Track_Valid, o_Cmd_Ready, o_Busy, o_Track};
        compared++;
        if (got !== {5'b00010, 7'd0}) begin
            mismatched++;
            $display("FAIL reset_mid_step: step/motor/valid/ready/busy/track=%b want %b",
                     got, {5'b00010, 7'd0});
        end
        i_Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seek_unrecal();
        test_recal();
        test_seek(7'd3, 1'b1, 3, {7'd1, 7'd2, 7'd3});
        test_seek(7'd1, 1'b0, 2, {7'd2, 7'd1, 7'd3});
        test_boundary();
        test_recal_fail();
        test_motor_off();
        test_reset_mid_step();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
